ysyx_25040101_sram_resp: RTL and testbench

Memory-side responder for the core's data-memory request/response bus: accepts one read or write request at a time, waits a fixed parameterised latency, and returns read data or a write acknowledgement. It sits outside `ysyx_25040101_riscv`, on the other end of the load/store path. It replaces the zero-latency simulator memory so the core and its bus handshake can be exercised against realistic, multi-cycle memory timing.

---
 rtl/ysyx_25040101_mem_pkg.sv | 7 +
 rtl/ysyx_25040101_sram_array.sv | 28 ++
 rtl/ysyx_25040101_sram_resp.sv | 85 ++++++++
 tb/tb_ysyx_25040101_sram_resp.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040101_mem_pkg.sv
// ysyx_25040101_mem_pkg: shared types and constants for the data-memory responder
`timescale 1ns/1ps
package ysyx_25040101_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
  localparam int MASK_W = 4;
endpackage

// File: rtl/ysyx_25040101_sram_array.sv
// ysyx_25040101_sram_array: DEPTH x 32 byte-enable write array with registered read, contents never reset
`timescale 1ns/1ps
module ysyx_25040101_sram_array
  import ysyx_25040101_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [31:0]       wdata,
  input  logic [MASK_W-1:0] wmask,
  output logic [31:0]       rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < MASK_W; i++)
          if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

// File: rtl/ysyx_25040101_sram_resp.sv
// ysyx_25040101_sram_resp: fixed-latency single-outstanding memory responder for the core's load/store bus
`timescale 1ns/1ps
module ysyx_25040101_sram_resp
  import ysyx_25040101_mem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic accept, fire, done, in_range, rd_sel;
  logic wen_q;
  logic [31:0] addr_q, wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic [32:0] off;
  logic [31:0] arr_rdata;
  // 33-bit offset: addresses below BASE_ADDR go negative and fail the bound check
  assign off      = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign in_range = off < SPAN;
  always_comb begin
    accept  = state == IDLE && req_valid && req_ready;
    fire    = state == BUSY && cnt == '0;
    done    = state == RESP && rsp_ready;
    state_n = accept ? BUSY : fire ? RESP : done ? IDLE : state;
    cnt_n   = accept ? CW'(LATENCY - 1) : (state == BUSY && cnt != '0) ? cnt - 1'b1 : cnt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_sel    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      req_ready <= state_n == IDLE;
      rsp_valid <= state_n == RESP;
      if (fire) begin
        rsp_err <= !in_range;
        rd_sel  <= in_range && !wen_q;
      end else if (done) begin
        rsp_err <= 1'b0;
        rd_sel  <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end
  end
  // array read register holds its value until the next access, so gating it with rd_sel keeps rsp_rdata stable
  assign rsp_rdata = rd_sel ? arr_rdata : '0;
  ysyx_25040101_sram_array #(.DEPTH(DEPTH)) u_array (
    .clk  (clk),
    .en   (fire && in_range),
    .we   (wen_q),
    .addr (off[AW+1:2]),
    .wdata(wdata_q),
    .wmask(wmask_q),
    .rdata(arr_rdata)
  );
endmodule

// File: tb/tb_ysyx_25040101_sram_resp.sv
// tb_ysyx_25040101_sram_resp: directed vector table plus reset, backpressure and mid-write reset sequences
`timescale 1ns/1ps
module tb_ysyx_25040101_sram_resp;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_wen = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_wmask = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int n_cmp = 0, n_err = 0;

  ysyx_25040101_sram_resp #(.DEPTH(1024), .LATENCY(2), .BASE_ADDR(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] wmask;
    logic [31:0] rdata;
    logic err;
  } vec_t;
  vec_t v [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) begin
      expire("rsp_valid");
      lat = -1;
    end
  endtask

  task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wmask, output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      expire("req_ready");
      req_valid = 1'b0; rd = 'x; er = 1'bx; lat = -1;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat;
    v[0]  = '{1'b1, 32'h8000_0000, 32'h0123_4567, 4'hF, 32'h0, 1'b0};
    v[1]  = '{1'b1, 32'h8000_0FFC, 32'h89AB_CDEF, 4'hF, 32'h0, 1'b0};
    v[2]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    v[3]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    v[4]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
    v[5]  = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0};
    v[6]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    v[7]  = '{1'b0, 32'h8000_0013, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    v[8]  = '{1'b0, 32'h8000_0023, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    v[9]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1};
    v[10] = '{1'b0, 32'h8000_1000, 32'h0,         4'h0, 32'h0, 1'b1};
    v[11] = '{1'b1, 32'h8000_1000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1};
    v[12] = '{1'b1, 32'h7FFF_FFFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1};
    v[13] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h0123_4567, 1'b0};
    v[14] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h89AB_CDEF, 1'b0};
    v[15] = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
    v[16] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    v[17] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_req_ready_low", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rel_req_ready_high", {31'b0, req_ready}, 32'd1);
    chk("rel_rsp_valid", {31'b0, rsp_valid}, 32'd0);

    for (int i = 0; i < 18; i++) begin
      txn(v[i].wen, v[i].addr, v[i].wdata, v[i].wmask, rd, er, lat);
      chk($sformatf("v%0d_rdata", i), rd, v[i].rdata);
      chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, v[i].err});
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd2);
      chk($sformatf("v%0d_idle", i), {30'b0, req_ready, rsp_valid}, 32'b10);
    end

    // backpressure with a pending request held high across the response
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010;
    @(posedge clk); #1;
    req_addr = 32'h8000_0020;
    wait_rsp(lat);
    chk("bp_lat", 32'(lat), 32'd2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_state", c), {30'b0, rsp_valid, req_ready}, 32'b10);
      chk($sformatf("bp%0d_rdata", c), rsp_rdata, 32'hDEAD_BEEF);
      chk($sformatf("bp%0d_err", c), {31'b0, rsp_err}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_after_hs", {30'b0, rsp_valid, req_ready}, 32'b01);
    @(posedge clk); #1;
    chk("bp_pending_accepted", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0;
    wait_rsp(lat);
    chk("bp2_lat", 32'(lat), 32'd2);
    chk("bp2_rdata", rsp_rdata, 32'h11BB_33DD);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // reset while a write to 0x8000_0020 sits in BUSY
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'h0; req_wmask = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_outputs", {rsp_rdata[29:0], req_ready, rsp_valid}, 32'd0);
    chk("mid_rst_err", {31'b0, rsp_err}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_hold", {rsp_rdata[29:0], req_ready, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    txn(1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, lat);
    chk("mid_rst_word", rd, 32'h11BB_33DD);
    chk("mid_rst_word_err", {31'b0, er}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
